imem_loader: RTL

- Byte-stream boot loader that programs the byte-addressed, little-endian instruction memory. It is the write-side counterpart to the read port that the fetch stage uses.
- Accepts a framed byte stream over a valid/ready handshake and assembles 32-bit instruction words. Each word is issued on a word-wide write port; memory stores it as bytes Addr..Addr+3, low byte first.
- Holds the core in reset (Core_Hold) until a frame loads with a verified checksum.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_word_packer.sv | 45 ++++
 rtl/imem_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and frame constants.
// State encoding and byte counts of the boot frame fields.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int CSUM_BYTES = 1;
  localparam int WORD_BYTES = 4;

  function automatic logic lane_last(
    input logic [1:0] lane
  );
    return lane == 2'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian words from bytes.
// Issues one registered write per completed 4-byte word.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  input  logic [15:0]       byte_idx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_word
);

  logic [23:0] lanes;

  // Lane capture; lane 3 completes the word and fires the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lanes       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_word <= '0;
    end else begin
      mem_we <= 1'b0;
      if (byte_en) begin
        if (lane_last(byte_idx[1:0])) begin
          mem_we      <= 1'b1;
          mem_addr    <= ADDR_W'({byte_idx[15:2], 2'b00});
          mem_wr_word <= {byte_data, lanes};
        end else begin
          unique case (byte_idx[1:0])
            2'd0:    lanes[7:0]   <= byte_data;
            2'd1:    lanes[15:8]  <= byte_data;
            default: lanes[23:16] <= byte_data;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for the imem.
// Holds the core in reset until a checksum-verified frame lands.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 120,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Restart,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wr_Word,
  output logic              Core_Hold,
  output logic              Load_Done,
  output logic              Load_Error,
  output logic [15:0]       Byte_Count
);

  state_t                      state;
  logic [8*LEN_BYTES-1:0]      len;
  logic [8*CSUM_BYTES-1:0]     csum;
  logic [8*CSUM_BYTES-1:0]     csum_nxt;
  logic [8*LEN_BYTES-1:0]      len_full;
  logic                        len_bad;
  logic                        xfer;
  logic                        last_byte;

  assign In_Ready  = (state != ST_DONE) &&
                     (state != ST_ERROR);
  assign xfer      = In_Valid && In_Ready;
  assign csum_nxt  = csum + In_Data;
  assign len_full  = {In_Data, len[7:0]};
  assign len_bad   = (len_full > 16'(MEM_BYTES)) ||
                     (len_full[1:0] != 2'b00);
  assign last_byte = (Byte_Count + 16'd1) == len;

  // Frame FSM: length, payload checksum, verdict and re-arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_LEN_LO;
      len        <= '0;
      csum       <= '0;
      Byte_Count <= '0;
      Core_Hold  <= 1'b1;
      Load_Done  <= 1'b0;
      Load_Error <= 1'b0;
    end else begin
      unique case (state)
        ST_LEN_LO: if (xfer) begin
          len[7:0] <= In_Data;
          state    <= ST_LEN_HI;
        end
        ST_LEN_HI: if (xfer) begin
          len[15:8] <= In_Data;
          if (len_bad) begin
            state      <= ST_ERROR;
            Load_Error <= 1'b1;
          end else if (len_full == '0) begin
            state <= ST_CSUM;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DATA: if (xfer) begin
          csum       <= csum_nxt;
          Byte_Count <= Byte_Count + 16'd1;
          if (last_byte) state <= ST_CSUM;
        end
        ST_CSUM: if (xfer) begin
          csum <= csum_nxt;
          if (csum_nxt == '0) begin
            state     <= ST_DONE;
            Load_Done <= 1'b1;
            Core_Hold <= 1'b0;
          end else begin
            state      <= ST_ERROR;
            Load_Error <= 1'b1;
          end
        end
        ST_DONE, ST_ERROR: if (Restart) begin
          state      <= ST_LEN_LO;
          len        <= '0;
          csum       <= '0;
          Byte_Count <= '0;
          Core_Hold  <= 1'b1;
          Load_Done  <= 1'b0;
          Load_Error <= 1'b0;
        end
        default: state <= ST_LEN_LO;
      endcase
    end
  end

  imem_word_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_en     (xfer && (state == ST_DATA)),
    .byte_data   (In_Data),
    .byte_idx    (Byte_Count),
    .mem_we      (Mem_We),
    .mem_addr    (Mem_Addr),
    .mem_wr_word (Mem_Wr_Word)
  );

endmodule
